// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode and ramp-direction constants for the PWM block.
package pwm_pkg;
  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk into a ramp-advance tick every prescale+1 cycles.
module pwm_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] prescale,
  output logic         tick
);
  logic [W-1:0] cnt;
  // >= rather than == so lowering prescale below the running count ticks at once
  assign tick = en && cnt >= prescale;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/pwm_multi_ramp.sv
// pwm_multi_ramp: shared sawtooth/triangle ramp compared against per-channel duty,
// with period, mode and duty double-buffered to take effect only at a period boundary.
module pwm_multi_ramp
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      period,
  input  logic                  duty_wr,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] duty_ch,
  input  logic [WIDTH-1:0]      duty_val,
  output logic [WIDTH-1:0]      ramp,
  output logic [CHANNELS-1:0]   pwm,
  output logic                  period_start
);
  logic                tick, bnd, down_step, load, mode_a;
  logic [WIDTH-1:0]    per_a, ramp_n;
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [WIDTH-1:0]    duty_a [CHANNELS];
  logic [CHANNELS-1:0] cmp;
  dir_e                dir, dir_n;

  pwm_prescaler #(.W(PRESCALE_W)) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .prescale (prescale),
    .tick     (tick)
  );

  // Triangle turns down at the top; reaching 1 on the way down ends the period,
  // which also covers per_a==1 (top and turnaround coincide).
  always_comb begin
    down_step = dir == DIR_DOWN || ramp == per_a;
    bnd       = mode_a == MODE_TRI ? per_a == '0 || (down_step && ramp == WIDTH'(1))
                                   : ramp == per_a;
    ramp_n    = !tick ? ramp
              : bnd ? '0
              : (mode_a == MODE_TRI && down_step) ? ramp - WIDTH'(1) : ramp + WIDTH'(1);
    dir_n     = !tick ? dir
              : (mode_a == MODE_TRI && !bnd && down_step) ? DIR_DOWN : DIR_UP;
    load      = !en || (tick && bnd);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cmp
    assign cmp[c] = ramp < duty_a[c];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ramp         <= '0;
      dir          <= DIR_UP;
      pwm          <= '0;
      period_start <= 1'b0;
      per_a        <= '0;
      mode_a       <= MODE_SAW;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        duty_a[i] <= '0;
      end
    end else begin
      ramp         <= en ? ramp_n : '0;
      dir          <= en ? dir_n : DIR_UP;
      pwm          <= en ? cmp : '0;
      period_start <= tick && bnd;
      if (load) begin
        per_a  <= period;
        mode_a <= mode;
      end
      // Active duty takes the pre-write shadow, so a boundary-cycle write lands one period later
      for (int i = 0; i < CHANNELS; i++) begin
        if (duty_wr && 32'(duty_ch) == i) shadow[i] <= duty_val;
        if (load) duty_a[i] <= shadow[i];
      end
    end
endmodule
